ras_ckpt: RTL and testbench

Parametrised return address stack with checkpoint/repair for the fetch-stage branch predictor. Calls detected in ID push their return address. Returns detected in IF pop a predicted target in the same cycle. Each prediction carries a pointer snapshot, so a branch mispredict can restore the stack pointer and occupancy instead of leaving the stack corrupted. The stack is a circular buffer that overwrites its oldest entry on overflow rather than refusing pushes.

---
 rtl/ras_pkg.sv | 27 ++
 rtl/ras_ckpt_if.sv | 34 +++
 rtl/ras_storage.sv | 29 ++
 rtl/ras_ckpt.sv | 112 +++++++++++
 tb/tb_ras_ckpt.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/ras_pkg.sv
// Shared definitions for the return address stack.
// Holds the pointer/count width helpers, the checkpoint layout for the
// default configuration and the overflow counter width.
package ras_pkg;

  localparam int RAS_DEPTH_DEFAULT = 32;
  localparam int OVF_CNT_W         = 16;

  // Width helpers so parametrised users can size tos/count for any DEPTH.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int PTR_W = $clog2(RAS_DEPTH_DEFAULT);
  localparam int CNT_W = $clog2(RAS_DEPTH_DEFAULT + 1);

  // Pointer snapshot carried with each prediction, default-depth layout.
  typedef struct packed {
    logic [PTR_W-1:0] tos;
    logic [CNT_W-1:0] count;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_if.sv
// Predictor-side bundle of the return address stack.
// master: fetch/decode side (drives push/pop/recover, receives prediction)
// slave : the stack itself
interface ras_ckpt_if #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
);
  import ras_pkg::*;

  localparam int CKPT_W = ptr_w(DEPTH) + cnt_w(DEPTH);

  logic                 push_valid;
  logic [ADDR_W-1:0]    push_pc;
  logic                 pop_valid;
  logic                 pred_hit;
  logic [ADDR_W-1:0]    pred_target;
  logic [CKPT_W-1:0]    ckpt;
  logic                 recover_valid;
  logic [CKPT_W-1:0]    recover_ckpt;
  logic                 empty;
  logic                 full;
  logic [OVF_CNT_W-1:0] overflow_cnt;

  modport master (
    output push_valid, push_pc, pop_valid, recover_valid, recover_ckpt,
    input  pred_hit, pred_target, ckpt, empty, full, overflow_cnt
  );

  modport slave (
    input  push_valid, push_pc, pop_valid, recover_valid, recover_ckpt,
    output pred_hit, pred_target, ckpt, empty, full, overflow_cnt
  );

endinterface

// File: rtl/ras_storage.sv
// Return address entry array: DEPTH x ADDR_W, one synchronous write port,
// one asynchronous read port.
// Ports: CLK, we/waddr/wdata (write), raddr/rdata (combinational read).
module ras_storage #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; count gates every read, so stale
  // contents are never observed and the array maps onto plain storage.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ras_ckpt.sv
// Return address stack with checkpoint/repair.
// Calls push pc+RET_OFFSET, returns pop a same-cycle prediction, and the
// {tos, count} snapshot lets a mispredict restore the pointers. Overflow
// overwrites the oldest entry and bumps a saturating counter.
// Ports: CLK, RESET (sync, active-high), bus (ras_ckpt_if.slave).
module ras_ckpt
  import ras_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = 32,
  parameter int RET_OFFSET = 8
) (
  input  logic     CLK,
  input  logic     RESET,
  ras_ckpt_if.slave bus
);

  localparam int TOS_W = ptr_w(DEPTH);
  localparam int CNT_N = cnt_w(DEPTH);

  typedef struct packed {
    logic [TOS_W-1:0] tos;
    logic [CNT_N-1:0] count;
  } ckpt_t;

  localparam logic [CNT_N-1:0] FULL_CNT = CNT_N'(DEPTH);

  logic [TOS_W-1:0]     tos_q, tos_d;
  logic [CNT_N-1:0]     count_q, count_d;
  logic [OVF_CNT_W-1:0] ovf_q, ovf_d;

  logic                 we;
  logic [TOS_W-1:0]     top_idx;
  logic [ADDR_W-1:0]    top_data;
  logic [ADDR_W-1:0]    ra;
  logic                 pred_hit;
  logic [ADDR_W-1:0]    pred_target;
  ckpt_t                rec;

  assign ra      = bus.push_pc + ADDR_W'(RET_OFFSET);
  assign top_idx = tos_q - TOS_W'(1);  // wraps mod DEPTH (power of two)
  assign rec     = ckpt_t'(bus.recover_ckpt);

  ras_storage #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .IDX_W  (TOS_W)
  ) u_storage (
    .CLK   (CLK),
    .we    (we),
    .waddr (tos_q),
    .wdata (ra),
    .raddr (top_idx),
    .rdata (top_data)
  );

  // NOTE: every signal gets a default before the branches, so no path
  // leaves a combinational output unassigned (no latches).
  always_comb begin
    tos_d       = tos_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    we          = 1'b0;
    pred_hit    = 1'b0;
    pred_target = '0;
    if (RESET) begin
      // State is cleared in the register process; suppress all side effects.
    end else if (bus.recover_valid) begin
      tos_d   = rec.tos;
      count_d = rec.count;
    end else if (bus.push_valid && bus.pop_valid) begin
      // Call in ID forwarding straight into a return in IF.
      pred_hit    = 1'b1;
      pred_target = ra;
    end else if (bus.push_valid) begin
      we    = 1'b1;
      tos_d = tos_q + TOS_W'(1);
      if (count_q != FULL_CNT) begin
        count_d = count_q + CNT_N'(1);
      end else if (ovf_q != '1) begin
        ovf_d = ovf_q + OVF_CNT_W'(1);
      end
    end else if (bus.pop_valid && (count_q != '0)) begin
      pred_hit    = 1'b1;
      pred_target = top_data;
      tos_d       = top_idx;
      count_d     = count_q - CNT_N'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tos_q   <= '0;
      count_q <= '0;
      ovf_q   <= '0;
    end else begin
      tos_q   <= tos_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.pred_hit     = pred_hit;
  assign bus.pred_target  = pred_target;
  assign bus.ckpt         = {tos_q, count_q};
  assign bus.empty        = (count_q == '0);
  assign bus.full         = (count_q == FULL_CNT);
  assign bus.overflow_cnt = ovf_q;

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed testbench for ras_ckpt at DEPTH=4 (ckpt = {tos[1:0], count[2:0]}).
module tb_ras_ckpt;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic CLK;
  logic RESET;

  int errors = 0;
  int checks = 0;

  ras_ckpt_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  ras_ckpt #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .RET_OFFSET (8)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; comb outputs settle by #1.
  task automatic drive(input logic push, input logic [31:0] pc, input logic pop,
                       input logic rec, input logic [4:0] rck);
    @(negedge CLK);
    bus.push_valid    = push;
    bus.push_pc       = pc;
    bus.pop_valid     = pop;
    bus.recover_valid = rec;
    bus.recover_ckpt  = rck;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'h0);
  endtask

  task automatic push(input logic [31:0] pc);
    drive(1'b1, pc, 1'b0, 1'b0, 5'h0);
  endtask

  task automatic pop_expect(input string tag, input logic hit, input logic [31:0] tgt);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'h0);
    check({tag, "_hit"}, 32'(bus.pred_hit), 32'(hit));
    check({tag, "_tgt"}, bus.pred_target, tgt);
  endtask

  logic [4:0] saved_ckpt;

  initial begin
    RESET             = 1'b1;
    bus.push_valid    = 1'b0;
    bus.push_pc       = '0;
    bus.pop_valid     = 1'b0;
    bus.recover_valid = 1'b0;
    bus.recover_ckpt  = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // Reset state, pop on empty stack misses
    pop_expect("rst_pop", 1'b0, 32'h0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_ckpt", 32'(bus.ckpt), 32'h0);
    check("rst_ovf", 32'(bus.overflow_cnt), 32'h0);

    // Two pushes then pops in LIFO order; ckpt shows pre-pop {tos=2,count=2}
    push(32'h0040_0100);
    push(32'h0040_0200);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'h0);
    check("lifo_ckpt", 32'(bus.ckpt), 32'h12);
    check("lifo_pop1_hit", 32'(bus.pred_hit), 32'd1);
    check("lifo_pop1_tgt", bus.pred_target, 32'h0040_0208);
    pop_expect("lifo_pop2", 1'b1, 32'h0040_0108);
    idle();
    check("lifo_empty", 32'(bus.empty), 32'd1);
    pop_expect("lifo_pop3", 1'b0, 32'h0);

    // Overflow: five pushes into four slots, oldest (0x18) lost
    push(32'h10);
    push(32'h20);
    push(32'h30);
    push(32'h40);
    idle();
    check("ovf_full4", 32'(bus.full), 32'd1);
    check("ovf_cnt4", 32'(bus.overflow_cnt), 32'd0);
    push(32'h50);
    idle();
    check("ovf_full5", 32'(bus.full), 32'd1);
    check("ovf_cnt5", 32'(bus.overflow_cnt), 32'd1);
    check("ovf_ckpt", 32'(bus.ckpt), 32'h0C);  // tos=1 (wrapped), count=4
    pop_expect("ovf_pop1", 1'b1, 32'h58);
    pop_expect("ovf_pop2", 1'b1, 32'h48);      // tos 0 -> 3 wrap
    pop_expect("ovf_pop3", 1'b1, 32'h38);
    pop_expect("ovf_pop4", 1'b1, 32'h28);
    pop_expect("ovf_pop5", 1'b0, 32'h0);
    check("ovf_empty", 32'(bus.empty), 32'd1);

    // Same-cycle push+pop bypass (tos=1 count=0 -> push -> tos=2 count=1)
    push(32'h100);
    drive(1'b1, 32'h300, 1'b1, 1'b0, 5'h0);
    check("byp_hit", 32'(bus.pred_hit), 32'd1);
    check("byp_tgt", bus.pred_target, 32'h308);
    idle();
    check("byp_ckpt", 32'(bus.ckpt), 32'h11);
    pop_expect("byp_pop", 1'b1, 32'h108);

    // Checkpoint repair (tos=1 count=0 before)
    push(32'hA00);
    push(32'hB00);
    idle();
    saved_ckpt = bus.ckpt;
    check("ck_saved", 32'(saved_ckpt), 32'h1A);  // tos=3 count=2
    push(32'h500);
    push(32'h600);
    pop_expect("ck_pop600", 1'b1, 32'h608);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 5'h1A);   // recover wins over pop
    check("ck_rec_hit", 32'(bus.pred_hit), 32'd0);
    idle();
    check("ck_restored", 32'(bus.ckpt), 32'h1A);
    pop_expect("ck_pop_top", 1'b1, 32'hB08);
    pop_expect("ck_pop_next", 1'b1, 32'hA08);

    // RESET beats recover_valid with count=3
    push(32'h1);
    push(32'h2);
    push(32'h3);
    idle();
    check("rr_count3", 32'(bus.ckpt[2:0]), 32'd3);
    @(negedge CLK);
    RESET             = 1'b1;
    bus.recover_valid = 1'b1;
    bus.recover_ckpt  = 5'h1A;
    bus.pop_valid     = 1'b1;
    #1;
    check("rr_hit", 32'(bus.pred_hit), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    bus.recover_valid = 1'b0;
    bus.pop_valid     = 1'b0;
    #1;
    check("rr_ckpt", 32'(bus.ckpt), 32'h0);
    check("rr_empty", 32'(bus.empty), 32'd1);
    check("rr_full", 32'(bus.full), 32'd0);
    check("rr_ovf", 32'(bus.overflow_cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
